sha256_compress: RTL

SHA256_COMPRESS -- requirements
Module: sha256_compress

---
 rtl/sha256_pkg.sv | 60 ++++++
 rtl/sha256_k_rom.sv | 11 +
 rtl/sha256_compress.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 round constants, initial hash values, state encoding and round helpers.
package sha256_pkg;

    typedef logic [0:7][31:0] hvec_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_UPDATE
    } state_e;

    localparam hvec_t IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam hvec_t IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    // s holds a..h in elements 0..7
    function automatic hvec_t sha_round(input hvec_t s,
                                        input logic [31:0] k,
                                        input logic [31:0] w);
        logic [31:0] t1;
        logic [31:0] t2;
        t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
    endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational lookup of the SHA-256 round constant K[idx].
module sha256_k_rom
    import sha256_pkg::*;
(
    input  logic [5:0]  idx_i,
    output logic [31:0] k_o
);

    assign k_o = K[idx_i];

endmodule

// File: rtl/sha256_compress.sv
// One-round-per-word SHA-256 compression core with chaining hash state.
// Optional SHA-224 IV selection when SHA256_COMPRESS_SHA224_EN is defined.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         hash_init,
    input  logic [31:0]  w_in,
    input  logic         w_in_vaild,
`ifdef SHA256_COMPRESS_SHA224_EN
    input  logic         mode_224,
`endif
    output logic [255:0] digest,
    output logic         chunk_done,
    output logic         busy,
    output logic         overrun
);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    hvec_t       h_q, h_d;
    hvec_t       v_q, v_d;
    logic        done_q, done_d;
    logic        ovr_q, ovr_d;
    hvec_t       h_base, iv_sel, src, rnd;
    logic [31:0] k_t;

`ifdef SHA256_COMPRESS_SHA224_EN
    logic mode_q, mode_d;
    logic pend_q, pend_d;

    // First cycle after reset re-loads H with the IV picked by mode_224
    assign iv_sel = mode_224 ? IV224 : IV256;
    assign h_base = pend_q ? iv_sel : h_q;
    assign digest = {h_q[0:6], mode_q ? 32'h0 : h_q[7]};
`else
    assign iv_sel = IV256;
    assign h_base = h_q;
    assign digest = h_q;
`endif

    sha256_k_rom u_k_rom (
        .idx_i (cnt_q),
        .k_o   (k_t)
    );

    assign src        = (state_q == S_IDLE) ? h_base : v_q;
    assign rnd        = sha_round(src, k_t, w_in);
    assign chunk_done = done_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = ovr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        h_d     = h_base;
        v_d     = v_q;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
`ifdef SHA256_COMPRESS_SHA224_EN
        mode_d  = pend_q ? mode_224 : mode_q;
        pend_d  = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (w_in_vaild) begin
                    v_d     = rnd;
                    cnt_d   = 6'd1;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (w_in_vaild) begin
                    v_d = rnd;
                    // count holds at 63 so it only wraps via UPDATE
                    if (cnt_q == 6'd63) begin
                        state_d = S_UPDATE;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            S_UPDATE: begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + v_q[i];
                end
                cnt_d   = 6'd0;
                state_d = S_IDLE;
                done_d  = 1'b1;
                if (w_in_vaild) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase
        if (hash_init) begin
            h_d     = iv_sel;
            state_d = S_IDLE;
            cnt_d   = 6'd0;
            done_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef SHA256_COMPRESS_SHA224_EN
            mode_d  = mode_224;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 6'd0;
            h_q     <= IV256;
            v_q     <= '0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h_q     <= h_d;
            v_q     <= v_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

`ifdef SHA256_COMPRESS_SHA224_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q <= 1'b0;
            pend_q <= 1'b1;
        end else begin
            mode_q <= mode_d;
            pend_q <= pend_d;
        end
    end
`endif

endmodule
